// File: rtl/pulsegen_multi.sv
// pulsegen_multi
//   Multi-channel programmable tick generator. Each of NUM_CH channels owns a
//   counter, a period register (period_max = period in clocks minus 1) and a
//   mode bit. Periodic mode emits a one-clock pulse every period_max+1 clocks
//   while enabled. One-shot mode emits a single pulse period_max+1 clocks
//   after a start trigger, with busy high while the count runs.
//
//   Optional feature: define PULSEGEN_RETRIGGER_EN to let start restart an
//   in-flight one-shot count. Left undefined, start is ignored while busy.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   en           per-channel enable; low holds the channel idle
//   cfg_we       one-cycle config write strobe
//   cfg_ch       channel addressed by cfg_we (out-of-range values are ignored)
//   cfg_period   new period_max
//   cfg_oneshot  new mode: 0 periodic, 1 one-shot
//   start        per-channel one-shot trigger
//   pulse        registered one-clock tick per channel
//   busy         one-shot count in progress per channel
module pulsegen_multi #(
  parameter int  NUM_CH         = 4,
  parameter int  CNT_WIDTH      = 32,
  parameter int  CLK_FREQ       = 100_000_000,
  parameter real DEFAULT_PERIOD = 0.015,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic                 cfg_oneshot,
  input  logic [NUM_CH-1:0]    start,
  output logic [NUM_CH-1:0]    pulse,
  output logic [NUM_CH-1:0]    busy
);

  localparam logic [CNT_WIDTH-1:0] DEFAULT_MAX =
    CNT_WIDTH'($rtoi(DEFAULT_PERIOD * CLK_FREQ - 1));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_max;
    logic                 oneshot;
    logic                 busy_r;
    logic                 pulse_r;
    logic                 cfg_hit;
    logic                 tc;

    assign cfg_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign tc      = (cnt == period_max);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt        <= '0;
        period_max <= DEFAULT_MAX;
        oneshot    <= 1'b0;
        busy_r     <= 1'b0;
        pulse_r    <= 1'b0;
      end else if (cfg_hit) begin
        // A write restarts the channel and wins over TC and start.
        period_max <= cfg_period;
        oneshot    <= cfg_oneshot;
        cnt        <= '0;
        busy_r     <= 1'b0;
        pulse_r    <= 1'b0;
      end else if (!en[i]) begin
        cnt     <= '0;
        busy_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else if (!oneshot) begin
        busy_r <= 1'b0;
        if (tc) begin
          cnt     <= '0;
          pulse_r <= 1'b1;
        end else begin
          cnt     <= cnt + CNT_WIDTH'(1);
          pulse_r <= 1'b0;
        end
      end else if (busy_r) begin
`ifdef PULSEGEN_RETRIGGER_EN
        if (start[i]) begin
          // Retrigger: reload the count and drop any coincident pulse.
          cnt     <= '0;
          pulse_r <= 1'b0;
        end else
`endif
        if (tc) begin
          cnt     <= '0;
          busy_r  <= 1'b0;
          pulse_r <= 1'b1;
        end else begin
          cnt     <= cnt + CNT_WIDTH'(1);
          pulse_r <= 1'b0;
        end
      end else begin
        // Idle one-shot: the start edge only arms the count, cnt stays 0,
        // so the pulse lands period_max+1 edges after start.
        cnt     <= '0;
        pulse_r <= 1'b0;
        busy_r  <= start[i];
      end
    end

    assign pulse[i] = pulse_r;
    assign busy[i]  = busy_r;
  end

endmodule

// File: tb/tb_pulsegen_multi.sv
// Testbench for pulsegen_multi: two instances (4 channels, and 3 channels so
// that one cfg_ch code is out of range) checked every cycle against an
// event-level model, plus directed literal checks.
module tb_pulsegen_multi;

`ifdef PULSEGEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en, start;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_oneshot;
  logic [3:0] pulse4, busy4;
  logic [2:0] pulse3, busy3;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulsegen_multi #(.NUM_CH(4), .CNT_WIDTH(8), .CLK_FREQ(1000), .DEFAULT_PERIOD(0.005)) u4 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start),
    .pulse(pulse4), .busy(busy4));

  pulsegen_multi #(.NUM_CH(3), .CNT_WIDTH(8), .CLK_FREQ(1000), .DEFAULT_PERIOD(0.005)) u3 (
    .clk(clk), .rst(rst), .en(en[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .start(start[2:0]),
    .pulse(pulse3), .busy(busy3));

  // Model: periodic channels count edges since (re)start and pulse on every
  // multiple of the period; one-shot channels hold the number of edges left
  // until their pulse (0 = idle).
  int         pm   [2][4];
  bit         os   [2][4];
  longint     run  [2][4];
  int         rem  [2][4];
  logic [3:0] ep   [2];
  logic [3:0] eb   [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        pm[d][c] = 4; os[d][c] = 1'b0; run[d][c] = 0; rem[d][c] = 0;
      end
      ep[d] = '0; eb[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int nch = (d == 0) ? 4 : 3;
      for (int c = 0; c < nch; c++) begin
        if (cfg_we && (int'(cfg_ch) == c)) begin
          pm[d][c] = int'(cfg_period); os[d][c] = cfg_oneshot;
          run[d][c] = 0; rem[d][c] = 0; ep[d][c] = 1'b0;
        end else if (!en[c]) begin
          run[d][c] = 0; rem[d][c] = 0; ep[d][c] = 1'b0;
        end else if (!os[d][c]) begin
          run[d][c]++;
          ep[d][c] = ((run[d][c] % longint'(pm[d][c] + 1)) == 0);
        end else if (rem[d][c] > 0) begin
          if (RETRIG && start[c]) begin
            rem[d][c] = pm[d][c] + 1; ep[d][c] = 1'b0;
          end else begin
            rem[d][c]--; ep[d][c] = (rem[d][c] == 0);
          end
        end else begin
          ep[d][c] = 1'b0;
          if (start[c]) rem[d][c] = pm[d][c] + 1;
        end
        eb[d][c] = (rem[d][c] > 0);
      end
    end
    ep[1][3] = 1'b0; eb[1][3] = 1'b0;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("pulse4", pulse4, ep[0]);
      check("busy4",  busy4,  eb[0]);
      check("pulse3", {1'b0, pulse3}, {1'b0, ep[1][2:0]});
      check("busy3",  {1'b0, busy3},  {1'b0, eb[1][2:0]});
    end
  end

  initial begin
    rst = 1'b1; en = '0; start = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_oneshot = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("lit_reset_pulse", pulse4, 4'b0000);
    check("lit_reset_busy",  busy4,  4'b0000);

    // Channel 0 periodic at the default period of 5 clocks.
    en = 4'b0001;
    tick(4);
    check("lit_ch0_edge4", pulse4, 4'b0000);
    tick(1);
    check("lit_ch0_edge5", pulse4, 4'b0001);
    check("lit_model_edge5", ep[0], 4'b0001);
    tick(1);
    check("lit_ch0_edge6", pulse4, 4'b0000);
    tick(4);
    check("lit_ch0_edge10", pulse4, 4'b0001);
    tick(5);
    check("lit_ch0_edge15", pulse4, 4'b0001);

    // Channel 2 with period_max 0, then 2.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd0; cfg_oneshot = 1'b0; en = 4'b0101;
    tick(1);
    check("lit_ch2_wr_cycle", {3'b0, pulse4[2]}, 4'd0);
    cfg_we = 1'b0;
    tick(1);
    check("lit_ch2_const1", {3'b0, pulse4[2]}, 4'd1);
    tick(3);
    check("lit_ch2_const2", {3'b0, pulse4[2]}, 4'd1);
    cfg_we = 1'b1; cfg_period = 8'd2;
    tick(1);
    check("lit_ch2_wr2_cycle", {3'b0, pulse4[2]}, 4'd0);
    cfg_we = 1'b0;
    tick(2);
    check("lit_ch2_p2_edge2", {3'b0, pulse4[2]}, 4'd0);
    tick(1);
    check("lit_ch2_p2_edge3", {3'b0, pulse4[2]}, 4'd1);

    // Channel 1 one-shot, period_max 3, second start two edges in.
    en = 4'b0111;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd3; cfg_oneshot = 1'b1;
    tick(1);
    cfg_we = 1'b0;
    tick(1);
    start = 4'b0010;
    tick(1);
    check("lit_os_busy_s0", {3'b0, busy4[1]}, 4'd1);
    start = 4'b0000;
    tick(1);
    start = 4'b0010;
    tick(1);
    start = 4'b0000;
    tick(1);
    check("lit_os_s3_pulse", {3'b0, pulse4[1]}, 4'd0);
    check("lit_os_s3_busy",  {3'b0, busy4[1]},  4'd1);
    tick(1);
    check("lit_os_s4_pulse", {3'b0, pulse4[1]}, {3'b0, !RETRIG});
    check("lit_os_s4_busy",  {3'b0, busy4[1]},  {3'b0, RETRIG});
    tick(1);
    check("lit_os_s5_pulse", {3'b0, pulse4[1]}, 4'd0);
    tick(1);
    check("lit_os_s6_pulse", {3'b0, pulse4[1]}, {3'b0, RETRIG});
    check("lit_os_s6_busy",  {3'b0, busy4[1]},  4'd0);

    // Abort an in-flight one-shot by dropping en.
    tick(2);
    start = 4'b0010;
    tick(1);
    start = 4'b0000;
    tick(1);
    en = 4'b0101;
    tick(1);
    check("lit_abort_busy",  {3'b0, busy4[1]},  4'd0);
    check("lit_abort_pulse", {3'b0, pulse4[1]}, 4'd0);
    en = 4'b0111;
    tick(5);
    check("lit_abort_nopulse", {3'b0, pulse4[1]}, 4'd0);

    // Asynchronous reset mid-count restores defaults.
    en = 4'b1111;
    tick(2);
    rst = 1'b1;
    #1;
    check("lit_rst_pulse4", pulse4, 4'b0000);
    check("lit_rst_busy4",  busy4,  4'b0000);
    check("lit_rst_pulse3", {1'b0, pulse3}, 4'b0000);
    tick(1);
    rst = 1'b0;
    tick(4);
    check("lit_post_rst_e4", pulse4, 4'b0000);
    // Write to ch2 coincident with its TC.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd4; cfg_oneshot = 1'b0;
    tick(1);
    check("lit_tc_wr_pulse4", pulse4, 4'b1011);
    check("lit_tc_wr_pulse3", {1'b0, pulse3}, 4'b0011);
    cfg_we = 1'b0;
    tick(1);
    // cfg_ch=3 is out of range for the 3-channel instance.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_period = 8'd0; cfg_oneshot = 1'b0;
    tick(1);
    cfg_we = 1'b0;
    tick(1);
    check("lit_oor_dut4_ch3", {3'b0, pulse4[3]}, 4'd1);
    check("lit_oor_dut3_e8",  {1'b0, pulse3}, 4'b0000);
    tick(2);
    check("lit_e10_pulse4", pulse4, 4'b1111);
    check("lit_e10_pulse3", {1'b0, pulse3}, 4'b0111);

    // Randomized traffic against the model.
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      start       = 4'($urandom) & 4'($urandom);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_ch      = 2'($urandom);
      cfg_period  = 8'($urandom_range(0, 7));
      cfg_oneshot = 1'($urandom);
      rst         = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0; cfg_we = 1'b0; start = '0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
